// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-byte I2C master sequencing START, address+R/W, one data byte, ACKs and STOP
module i2c_master_ctrl #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_req,
   input  logic       rw,
   input  logic [6:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   inout  wire        scl,
   inout  wire        sda
);
   localparam int CW = $clog2(CLK_DIV);
   typedef enum logic [3:0] {IDLE, START, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_NACK, STOP} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [1:0] q, sda_s;
   logic [2:0] bits;
   logic [7:0] abyte, wbyte, rx;
   logic scl_low, sda_low, adv, q_end, slot_end, sample;
   assign scl = scl_low ? 1'b0 : 1'bz;
   assign sda = sda_low ? 1'b0 : 1'bz;
   assign busy = state != IDLE;
   // a slave holding SCL low in q1 stretches the clock by freezing the quarter counter
   assign adv = !(q == 2'd1 && !scl);
   assign q_end = adv && cnt == CW'(CLK_DIV - 1);
   assign slot_end = q_end && q == 2'd3;
   assign sample = q == 2'd2 && cnt == '0;
   assign scl_low = (state == START) ? q == 2'd3 :
                    (state == STOP)  ? q == 2'd0 :
                    (state != IDLE) && (q == 2'd0 || q == 2'd3);
   assign sda_low = (state == START) ? q[1] :
                    (state == STOP)  ? !q[1] :
                    (state == ADDR)  ? !abyte[bits] :
                    (state == WRITE) ? !wbyte[bits] : 1'b0;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:     if (start_req) state_n = START;
         START:    if (slot_end) state_n = ADDR;
         ADDR:     if (slot_end && bits == 3'd0) state_n = ADDR_ACK;
         ADDR_ACK: if (slot_end) state_n = ack_err ? STOP : abyte[0] ? READ : WRITE;
         WRITE:    if (slot_end && bits == 3'd0) state_n = WR_ACK;
         WR_ACK:   if (slot_end) state_n = STOP;
         READ:     if (slot_end && bits == 3'd0) state_n = RD_NACK;
         RD_NACK:  if (slot_end) state_n = STOP;
         STOP:     if (slot_end) state_n = IDLE;
         default:  state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         q       <= '0;
         bits    <= '0;
         abyte   <= '0;
         wbyte   <= '0;
         rx      <= '0;
         rdata   <= '0;
         ack_err <= 1'b0;
         done    <= 1'b0;
         sda_s   <= 2'b11;
      end else begin
         sda_s <= {sda_s[0], sda};
         done  <= state == STOP && slot_end;
         if (state == IDLE) begin
            cnt  <= '0;
            q    <= '0;
            bits <= 3'd7;
            if (start_req) begin
               abyte   <= {addr, rw};
               wbyte   <= wdata;
               ack_err <= 1'b0;
            end
         end else if (adv) begin
            cnt <= q_end ? '0 : cnt + 1'b1;
            if (q_end) q <= q + 1'b1;
            if (slot_end && state inside {ADDR, WRITE, READ}) bits <= bits - 1'b1;
         end
         if (sample && state inside {ADDR_ACK, WR_ACK} && sda_s[1]) ack_err <= 1'b1;
         if (sample && state == READ) rx <= {rx[6:0], sda_s[1]};
         if (slot_end && state == RD_NACK) rdata <= rx;
      end
   end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: directed bench with a behavioural I2C slave on pulled-up SCL/SDA
module tb_i2c_master_ctrl;
   localparam int D = 4;
   logic clk = 1'b0, rst = 1'b1, start_req = 1'b0, rw = 1'b0;
   logic [6:0] addr = '0;
   logic [7:0] wdata = '0, rdata;
   logic busy, done, ack_err;
   wire scl, sda;
   logic s_scl_low = 1'b0, s_sda_low = 1'b0, scl_prev = 1'b1;
   logic addr_ack = 1'b1, data_ack = 1'b1;
   logic [7:0] s_rdata = 8'h00;
   logic [31:0] log_bits = '0;
   int k = 0, n_cmp = 0, n_bad = 0, lat = 0;
   pullup (scl);
   pullup (sda);
   assign scl = s_scl_low ? 1'b0 : 1'bz;
   assign sda = s_sda_low ? 1'b0 : 1'bz;
   i2c_master_ctrl #(.CLK_DIV(D)) dut (
      .clk(clk), .rst(rst), .start_req(start_req), .rw(rw), .addr(addr), .wdata(wdata),
      .rdata(rdata), .busy(busy), .done(done), .ack_err(ack_err), .scl(scl), .sda(sda)
   );
   always #5 clk = ~clk;
   // slave: logs SDA at every SCL rise, restarts on START, drives ACK/read bits while SCL is low
   always @(posedge scl or negedge scl or negedge sda) begin
      if (scl !== scl_prev) begin
         if (scl === 1'b1) begin
            log_bits = {log_bits[30:0], sda};
            k = k + 1;
         end else
            s_sda_low = (k == 8) ? addr_ack :
                        (k >= 9 && k <= 16 && rw) ? !s_rdata[16 - k] :
                        (k == 17 && !rw) ? data_ack : 1'b0;
      end else if (scl === 1'b1) begin
         k = 0;
         log_bits = '0;
      end
      scl_prev = scl;
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic wait_done(input int budget);
      lat = 0;
      while (!done && lat < budget) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask
   task automatic xfer(input logic r, input logic [6:0] a, input logic [7:0] w, input logic hold);
      rw = r;
      addr = a;
      wdata = w;
      start_req = 1'b1;
      @(posedge clk);
      #1 start_req = hold;
      check("busy_at_accept", busy, 1);
      wait_done(1000);
   endtask
   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_scl", scl, 1);
      check("rst_sda", sda, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ack_err", ack_err, 0);
      check("rst_rdata", rdata, 8'h00);
      rst = 1'b0;
      @(posedge clk);
      #1;
      // write 0x05 <- 0xCC, all ACKed
      xfer(1'b0, 7'h05, 8'hCC, 1'b0);
      check("wr_latency", lat, 320);
      check("wr_busy_in_done", busy, 0);
      check("wr_ack_err", ack_err, 0);
      check("wr_rdata_held", rdata, 8'h00);
      check("wr_bits", log_bits, {13'd0, 7'h05, 1'b0, 1'b0, 8'hCC, 1'b0, 1'b0});
      @(posedge clk);
      #1 check("done_one_cycle", done, 0);
      // read 0xA5 from 0x05, master NACKs
      s_rdata = 8'hA5;
      xfer(1'b1, 7'h05, 8'h00, 1'b0);
      check("rd_latency", lat, 320);
      check("rd_rdata", rdata, 8'hA5);
      check("rd_ack_err", ack_err, 0);
      check("rd_bits", log_bits, {13'd0, 7'h05, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0});
      // address NACK
      addr_ack = 1'b0;
      xfer(1'b0, 7'h05, 8'hCC, 1'b0);
      addr_ack = 1'b1;
      check("nack_latency", lat, 176);
      check("nack_ack_err", ack_err, 1);
      check("nack_bits", log_bits, {22'd0, 7'h05, 1'b0, 1'b1, 1'b0});
      check("nack_rdata_held", rdata, 8'hA5);
      // 37-clock stretch during the address ACK q1
      fork
         xfer(1'b0, 7'h05, 8'hCC, 1'b0);
         begin : stretch
            int m;
            m = 0;
            while (k != 0 && m < 2000) begin @(posedge clk); #1 m++; end
            while (k < 8 && m < 2000) begin @(posedge clk); #1 m++; end
            while (scl !== 1'b0 && m < 2000) begin @(posedge clk); #1 m++; end
            s_scl_low = 1'b1;
            repeat (2 * D + 37) @(posedge clk);
            #1 s_scl_low = 1'b0;
         end
      join
      check("stretch_latency", lat, 357);
      check("stretch_bits", log_bits, {13'd0, 7'h05, 1'b0, 1'b0, 8'hCC, 1'b0, 1'b0});
      check("stretch_rdata_held", rdata, 8'hA5);
      // reset while the 4th data bit is on the bus
      begin : mid_reset
         int m;
         logic seen;
         rw = 1'b0;
         addr = 7'h05;
         wdata = 8'hCC;
         start_req = 1'b1;
         @(posedge clk);
         #1 start_req = 1'b0;
         m = 0;
         while (!(k >= 13 && scl === 1'b0) && m < 2000) begin @(posedge clk); #1 m++; end
         check("mid_reached_bit4", m < 2000, 1);
         check("mid_sda_driven", sda, 0);
         rst = 1'b1;
         #1;
         check("mid_scl_released", scl, 1);
         check("mid_sda_released", sda, 1);
         check("mid_busy", busy, 0);
         seen = done;
         repeat (3) begin @(posedge clk); #1 seen |= done; end
         rst = 1'b0;
         repeat (100) begin @(posedge clk); #1 seen |= done; end
         check("mid_no_done", seen, 0);
      end
      xfer(1'b0, 7'h05, 8'hCC, 1'b0);
      check("post_rst_latency", lat, 320);
      check("post_rst_bits", log_bits, {13'd0, 7'h05, 1'b0, 1'b0, 8'hCC, 1'b0, 1'b0});
      // START_REQ held high: NACKed transfer, then back-to-back write
      addr_ack = 1'b0;
      xfer(1'b0, 7'h05, 8'hCC, 1'b1);
      check("b2b_first_latency", lat, 176);
      check("b2b_first_ack_err", ack_err, 1);
      check("b2b_busy_in_done", busy, 0);
      addr_ack = 1'b1;
      @(posedge clk);
      #1 start_req = 1'b0;
      check("b2b_second_busy", busy, 1);
      check("b2b_ack_err_cleared", ack_err, 0);
      wait_done(1000);
      check("b2b_second_latency", lat, 320);
      check("b2b_second_bits", log_bits, {13'd0, 7'h05, 1'b0, 1'b0, 8'hCC, 1'b0, 1'b0});
      check("b2b_second_ack_err", ack_err, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
Single-byte I2C master controller that sequences a complete bus transaction for the team's I2C slave: START, 7-bit address plus R/W, one data byte written or read, ACK handling, then STOP. It runs from the system clock and drives the shared open-drain SCL/SDA bus. A simple request/busy/done command interface lets host logic issue one transfer at a time.

Parameters:
CLK_DIV, 4, system clocks per SCL quarter-period. Legal range is 2 or more. SCL period = 4*CLK_DIV clocks.

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-high reset
START_REQ  input  1  transfer request; sampled only in IDLE
RW  input  1  0 = write WDATA, 1 = read into RDATA; captured with START_REQ
ADDR  input  7  slave address; captured with START_REQ
WDATA  input  8  write byte; captured with START_REQ
RDATA  output  8  last byte read
BUSY  output  1  transaction in progress
DONE  output  1  one-cycle pulse at transaction end
ACK_ERR  output  1  slave NACKed the last transaction
SCL  inout  1  open-drain: drives 0 or z
SDA  inout  1  open-drain: drives 0 or z

Behaviour:
- Reset: SCL=z, SDA=z, BUSY=0, DONE=0, ACK_ERR=0, RDATA=8'h00, FSM=IDLE, counters cleared.
- Reset mid-transaction: bus is released immediately. No STOP is generated and DONE does not pulse.
- Accepting a request:
  - START_REQ=1 in IDLE at edge E latches ADDR, RW and WDATA.
  - BUSY=1 from E. ACK_ERR clears at E.
  - START_REQ while BUSY=1 is ignored. Nothing is queued.
- Bit slots and quarter timing:
  - Each bit slot is 4 quarters, q0..q3, and each quarter lasts CLK_DIV clocks.
  - Data/ACK slot: q0 SCL=0 and SDA updated; q1 SCL released; q2 SCL high and SDA sampled on the first clock of q2; q3 SCL=0.
  - START slot: q0 and q1 SDA=z, SCL=z; q2 SDA=0, SCL=z; q3 SDA=0, SCL=0.
  - STOP slot: q0 SDA=0, SCL=0; q1 SDA=0, SCL=z; q2 and q3 SDA=z, SCL=z.
- Clock stretching: in q1 the quarter counter holds while SCL reads 0. It advances only once SCL reads 1. All latencies below assume no stretching.
- FSM states: IDLE -> START -> ADDR (8 slots: ADDR[6:0] MSB first, then RW) -> ADDR_ACK.
  - ADDR_ACK, SDA sampled 0: go to WRITE if RW=0, READ if RW=1.
  - ADDR_ACK, SDA sampled 1: set ACK_ERR=1 and go to STOP.
  - WRITE (8 slots, WDATA MSB first) -> WR_ACK. If WR_ACK samples 1, set ACK_ERR=1. Either way go to STOP.
  - READ: SDA=z for 8 slots. Shift in MSB first at each q2 sample.
  - READ -> RD_NACK: master leaves SDA=z (NACK, single byte) -> STOP.
  - RDATA updates at the end of RD_NACK. It is otherwise held, including across write transactions.
  - STOP -> IDLE.
- Completion: on leaving STOP, DONE=1 for exactly one cycle and BUSY=0 in that same cycle. A new START_REQ is accepted in the DONE cycle.
- Latency, counted from the accept edge E to the DONE-high cycle:
  - Full transaction (1 + 9 + 9 + 1 = 20 slots): 80*CLK_DIV clocks.
  - Address NACK (11 slots): 44*CLK_DIV clocks.
- SCL/SDA are never driven to 1. The bench must provide pull-ups.
- Read data on SDA is taken from a 2-flop synchronizer, so sampling uses data 2 clocks old. CLK_DIV of 2 or more guarantees stable data.

Test Plan:
1. Reset, then write. CLK_DIV=4, ADDR=7'h05, RW=0, WDATA=8'hCC, slave ACKs all -> SDA bits are 0000101 0 ACK 11001100 ACK. DONE pulses at E+320 clocks. ACK_ERR=0 and RDATA stays 8'h00.
2. Read. ADDR=7'h05, RW=1, slave returns 8'hA5 -> master releases SDA in the 9th data slot (NACK). RDATA=8'hA5 in the DONE cycle, at E+320 clocks.
3. Address NACK. Slave leaves SDA high on the address ACK -> no data slots are issued. STOP follows, ACK_ERR=1, DONE at E+176 clocks.
4. Clock stretching. Slave holds SCL low for 37 clocks during the address ACK q1 -> every SCL edge after that point shifts by 37 clocks. DONE arrives at E+357 and the bit values are unchanged.
5. Reset mid-byte. Assert RESET during the 4th WDATA bit -> SCL and SDA go z immediately, BUSY=0, no DONE pulse. A new request after reset completes normally.
6. START_REQ held high throughout, plus back-to-back requests -> the mid-transfer request is ignored. The second transaction's START begins the cycle after DONE, and ACK_ERR clears at that accept.
